// File: rtl/pending_encoder_32x5.sv
// rtl/pending_encoder_32x5.sv - sticky 32-line request capture with 5-bit valid/ack index output
module pending_encoder_32x5 #(
  parameter bit RR = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] REQ,
  input  logic        ACK,
  output logic        VALID,
  output logic [4:0]  IDX,
  output logic [31:0] PEND
);

  logic [31:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  ptr_q, ptr_d;

  logic        xfer;
  logic [31:0] clr;
  logic [31:0] cand;
  logic [31:0] rot;
  logic [4:0]  low_idx;
  logic [4:0]  rr_off;
  logic [4:0]  rr_idx;
  logic [4:0]  sel_idx;

  // Index of the lowest set bit; caller only uses it when the vector is non-zero.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Handshake, clear mask and the two selection policies over the candidate set.
  always_comb begin
    xfer    = valid_q & ACK;
    clr     = xfer ? (32'd1 << idx_q) : 32'd0;
    // Candidates exclude same-edge REQ so a fresh request never bypasses the pending register.
    cand    = pend_q & ~clr;
    low_idx = lowest_set(cand);
    // Rotate so that bit PTR lands at position 0; a shift of 32 yields zero, covering PTR=0.
    rot     = (cand >> ptr_q) | (cand << (6'd32 - {1'b0, ptr_q}));
    rr_off  = lowest_set(rot);
    rr_idx  = ptr_q + rr_off;
    sel_idx = RR ? rr_idx : low_idx;
  end

  // Next-state: set-wins-over-clear pending update, output load on idle or transfer, pointer advance.
  always_comb begin
    pend_d  = cand | REQ;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (!valid_q || xfer) begin
      if (|cand) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (xfer) begin
      ptr_d = idx_q + 5'd1;
    end
  end

  // State registers with asynchronous clear; REQ has no effect while reset is held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q  <= 32'd0;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      ptr_q   <= 5'd0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign VALID = valid_q;
  assign IDX   = idx_q;
  assign PEND  = pend_q;

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// tb/tb_pending_encoder_32x5.sv - scoreboard bench for pending_encoder_32x5 in both arbitration modes
module tb_pending_encoder_32x5;

  logic        CLK = 1'b0;
  logic        rst0, rst1;
  logic [31:0] req0, req1;
  logic        ack0, ack1;
  logic        valid0, valid1;
  logic [4:0]  idx0, idx1;
  logic [31:0] pend0, pend1;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp0_q[$];
  logic [4:0] exp1_q[$];

  pending_encoder_32x5 #(.RR(1'b0)) dut0 (
    .CLK(CLK), .RESET(rst0), .REQ(req0), .ACK(ack0),
    .VALID(valid0), .IDX(idx0), .PEND(pend0)
  );

  pending_encoder_32x5 #(.RR(1'b1)) dut1 (
    .CLK(CLK), .RESET(rst1), .REQ(req1), .ACK(ack1),
    .VALID(valid1), .IDX(idx1), .PEND(pend1)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented index is compared against the scoreboard head; popped on transfer.
  always @(negedge CLK) begin
    if (!rst0 && valid0) begin
      checks++;
      if (exp0_q.size() == 0) begin
        failures++;
        $display("FAIL mon0_unexpected actual=%0d expected=none", idx0);
      end else begin
        if (idx0 !== exp0_q[0]) begin
          failures++;
          $display("FAIL mon0_idx actual=%0d expected=%0d", idx0, exp0_q[0]);
        end
        if (ack0) void'(exp0_q.pop_front());
      end
      checks++;
      if (pend0[idx0] !== 1'b1) begin
        failures++;
        $display("FAIL mon0_pend_invariant actual=%0h expected_bit=%0d", pend0, idx0);
      end
    end
    if (!rst1 && valid1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL mon1_unexpected actual=%0d expected=none", idx1);
      end else begin
        if (idx1 !== exp1_q[0]) begin
          failures++;
          $display("FAIL mon1_idx actual=%0d expected=%0d", idx1, exp1_q[0]);
        end
        if (ack1) void'(exp1_q.pop_front());
      end
    end
  end

  initial begin
    int vcnt;
    logic [31:0] one_hot;
    rst0 = 1'b1; rst1 = 1'b1;
    req0 = 32'd0; req1 = 32'd0;
    ack0 = 1'b0; ack1 = 1'b0;
    #2;
    chk("rst_pend0", pend0, 32'd0);
    chk("rst_valid0", {31'd0, valid0}, 32'd0);
    chk("rst_idx0", {27'd0, idx0}, 32'd0);
    chk("rst_valid1", {31'd0, valid1}, 32'd0);
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Fixed priority burst: 4, 15, 31 with ACK held high.
    exp0_q.push_back(5'd4); exp0_q.push_back(5'd15); exp0_q.push_back(5'd31);
    req0 = 32'h8000_8010; ack0 = 1'b1;
    tick();
    req0 = 32'd0;
    chk("fp_latency_valid", {31'd0, valid0}, 32'd0);
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid0) vcnt++;
    end
    chk("fp_valid_cycles", 32'(vcnt), 32'd3);
    chk("fp_pend_empty", pend0, 32'd0);
    ack0 = 1'b0;

    // Stall with ACK low; a lower request arriving mid-stall must not disturb IDX.
    exp0_q.push_back(5'd1); exp0_q.push_back(5'd0); exp0_q.push_back(5'd2);
    req0 = 32'h6;
    tick();
    req0 = 32'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      req0 = (c == 1) ? 32'h1 : 32'h0;
    end
    req0 = 32'd0;
    chk("stall_idx", {27'd0, idx0}, 32'd1);
    chk("stall_valid", {31'd0, valid0}, 32'd1);
    chk("stall_pend", pend0, 32'h7);
    ack0 = 1'b1;
    tick(); tick(); tick();
    ack0 = 1'b0;
    chk("stall_done_valid", {31'd0, valid0}, 32'd0);
    chk("stall_done_pend", pend0, 32'd0);

    // Set wins over clear on the transfer edge, with one bubble cycle.
    exp0_q.push_back(5'd3); exp0_q.push_back(5'd3);
    req0 = 32'h8;
    tick();
    req0 = 32'd0;
    tick();
    chk("svc_present", {27'd0, idx0}, 32'd3);
    ack0 = 1'b1; req0 = 32'h8;
    tick();
    ack0 = 1'b0; req0 = 32'd0;
    chk("svc_bubble_valid", {31'd0, valid0}, 32'd0);
    chk("svc_pend_kept", pend0, 32'h8);
    tick();
    chk("svc_represent_valid", {31'd0, valid0}, 32'd1);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    chk("svc_done_valid", {31'd0, valid0}, 32'd0);

    // Encoder/decoder cross-check over all 32 lines.
    for (int i = 0; i < 32; i++) begin
      exp0_q.push_back(5'(i));
      req0 = 32'd1 << i;
      tick();
      req0 = 32'd0;
      chk("xchk_edge1_valid", {31'd0, valid0}, 32'd0);
      tick();
      chk("xchk_edge2_valid", {31'd0, valid0}, 32'd1);
      one_hot = 32'd1 << idx0;
      chk("xchk_decode", one_hot, 32'd1 << i);
      ack0 = 1'b1;
      tick();
      ack0 = 1'b0;
      chk("xchk_clear", pend0, 32'd0);
    end

    // Asynchronous reset in the middle of a transfer burst.
    exp0_q.push_back(5'd0);
    req0 = 32'hFFFF_FFFF;
    tick(); tick();
    ack0 = 1'b1;
    tick();
    rst0 = 1'b1;
    #1;
    chk("arst_pend", pend0, 32'd0);
    chk("arst_valid", {31'd0, valid0}, 32'd0);
    chk("arst_idx", {27'd0, idx0}, 32'd0);
    tick(); tick();
    chk("arst_req_ignored", pend0, 32'd0);
    req0 = 32'd0; ack0 = 1'b0;
    rst0 = 1'b0;
    tick(); tick(); tick();
    chk("arst_post_valid", {31'd0, valid0}, 32'd0);

    // Round-robin: move PTR to 1, then 0x80000003 must go 1, 31, 0.
    exp1_q.push_back(5'd0);
    req1 = 32'h1;
    tick();
    req1 = 32'd0;
    tick();
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("rr_ptr_prep", {27'd0, dut1.ptr_q}, 32'd1);
    exp1_q.push_back(5'd1); exp1_q.push_back(5'd31); exp1_q.push_back(5'd0);
    req1 = 32'h8000_0003;
    tick();
    req1 = 32'd0;
    tick();
    chk("rr_first", {27'd0, idx1}, 32'd1);
    ack1 = 1'b1;
    tick();
    chk("rr_second", {27'd0, idx1}, 32'd31);
    tick();
    chk("rr_wrap", {27'd0, idx1}, 32'd0);
    tick();
    ack1 = 1'b0;
    chk("rr_done_valid", {31'd0, valid1}, 32'd0);
    chk("rr_ptr_final", {27'd0, dut1.ptr_q}, 32'd1);

    tick();
    chk("sb0_drained", 32'(exp0_q.size()), 32'd0);
    chk("sb1_drained", 32'(exp1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pending_encoder_32x5.md
# pending_encoder_32x5

Sequential 32-to-5 request encoder: the inverse of the 5x32 line decoder used for register-select. Captures 32 request lines into a sticky pending register and presents one pending index at a time as a 5-bit binary code with a valid/ack handshake, clearing each index once it is consumed. Sits on the request side of the register-file / interrupt path and feeds the 5-bit index back to the decoder-based select logic.

## Interface
- RR, default 0: arbitration policy. 0 = fixed priority, lowest index wins. 1 = round-robin, search starts one above the last acknowledged index.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  32  request lines, sampled every rising edge; a 1 sets the corresponding pending bit.
- ACK  input  1  consumer accepts the presented index; meaningful only while VALID=1.
- VALID  output  1  IDX holds a pending request.
- IDX  output  5  binary index of the presented request.
- PEND  output  32  pending register, for observation.

## Operation
- State: PEND[31:0], VALID, IDX[4:0], PTR[4:0] (search start; used only when RR=1). All are registers.
- RESET asserted, at any time including mid-handshake: immediately PEND=0, VALID=0, IDX=0, PTR=0. REQ is ignored while RESET=1.
- Handshake: a transfer (XFER) occurs on an edge where VALID=1 and ACK=1. ACK while VALID=0 is ignored.
- CLR = one-hot(IDX) if XFER, else 0.
- PEND update: PEND <= (PEND & ~CLR) | REQ. Set wins over clear: if REQ[IDX]=1 on the XFER edge, that bit stays pending.
- Candidate set: C = PEND & ~CLR. It uses current PEND only; REQ from the same edge is not included.
- Output update:
  - VALID=1 and no XFER: hold VALID and IDX unchanged, regardless of REQ.
  - VALID=0 or XFER: if C≠0, VALID<=1 and IDX<=sel(C). Otherwise VALID<=0 and IDX holds its last value.
- sel, RR=0: lowest set bit of C.
- sel, RR=1: first set bit of C scanning PTR, PTR+1, …, 31, 0, …, PTR-1 (mod 32).
- PTR update: on XFER, PTR <= IDX+1 mod 32, so 31 wraps to 0. PTR does not change otherwise. When RR=0, PTR is don't-care but still resets to 0.
- Invariant: while VALID=1, PEND[IDX]=1. The same index is never presented twice for one request.

## Timing
- REQ[i] high at edge k sets PEND[i] at edge k.
- With the block idle (VALID=0), VALID=1 and IDX=i appear after edge k+1. Request-to-valid latency is 2 edges.
- Back-to-back: on an XFER edge the next index is loaded in the same edge. VALID stays high with no bubble while other bits are pending, giving 1 index per cycle with ACK held high.
- Last pending bit acknowledged: VALID=0 after that edge.
- A request that arrives on the XFER edge that empties C appears 1 cycle later. VALID shows one low cycle.
- IDX and VALID are glitch-free registered outputs. No combinational path from REQ or ACK to any output.

## Test plan
- Reset: drive REQ=FFFFFFFF and assert RESET mid-transfer -> PEND=0, VALID=0, IDX=0 asynchronously. After release with REQ=0, VALID stays 0.
- Fixed priority, RR=0: pulse REQ=0x80008010 for 1 cycle, hold ACK=1 -> IDX sequence 4, 15, 31 on consecutive cycles, VALID high for exactly 3 cycles, then PEND=0.
- Stall: REQ pulse 0x00000006, ACK=0 for 5 cycles -> IDX=1 held stable with VALID=1. Add REQ=0x1 during the stall -> IDX still 1. After ACK: IDX 0, then 2.
- Set-vs-clear: present IDX=3, then drive ACK=1 and REQ=0x8 on the same edge -> PEND[3] stays 1, VALID drops for 1 cycle, then IDX=3 again.
- Round-robin wrap, RR=1: pending 0x80000003, acknowledge IDX=1 -> next IDX=31, then IDX=0. PTR=1 after the final XFER.
- Encoder/decoder cross-check: for each i=0..31, single-bit REQ=1<<i -> IDX=i after 2 edges, and decoding IDX through the 5x32 decoder reproduces 1<<i.
